vga_console_ctrl: RTL and testbench

Text-console sequencer for the 80x60 VGA character RAM. It accepts a stream of 7-bit ASCII characters from the CPU and places them at a hardware-maintained cursor. It also handles the control codes CR, LF, BS and FF. It scrolls a scroll region of the top ROWS lines by copying characters through the single shared RAM port. Row 59, the status line, is never touched by this block. It sits between the CPU I/O decoder and the write/read port of the character RAM.

---
 rtl/vga_console_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_vga_console_ctrl.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_console_ctrl.sv
// ---------------------------------------------------------------------------
// vga_console_ctrl
//
// Text-console sequencer for the 80x60 VGA character RAM. Takes a stream of
// 7-bit ASCII characters and places them at a hardware cursor. Handles the
// control codes CR, LF, BS and FF. Scrolls the top ROWS lines by copying
// characters through the single shared RAM port. The status line (row
// ROWS, i.e. row 59) is never written.
//
// Ports
//   sys_clk   in   system clock
//   clrn      in   asynchronous active-low reset
//   ch_valid  in   character offered
//   ch_data   in   7-bit ASCII code
//   ch_ready  out  character accepted on a cycle with ch_valid & ch_ready
//   busy      out  high in any state other than IDLE
//   cur_row   out  cursor row, 0..ROWS-1
//   cur_col   out  cursor column, 0..COLS-1
//   ram_a     out  character RAM address, row*COLS+col
//   ram_d     out  character RAM write data
//   ram_we    out  character RAM write enable
//   ram_q     in   character RAM read data (combinational from ram_a)
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a character, ch_ready=1
// PUT     | one write at the cursor (printable char or BS blank)
// SCR_RD  | read character i+COLS into the holding register
// SCR_WR  | write the holding register to address i
// SCR_CLR | blank the last scroll-region row, one column per cycle
// CLR     | blank the whole scroll region, one address per cycle
// ---------------------------------------------------------------------------
module vga_console_ctrl #(
  parameter int COLS = 80,
  parameter int ROWS = 59
) (
  input  logic        sys_clk,
  input  logic        clrn,
  input  logic        ch_valid,
  input  logic [6:0]  ch_data,
  output logic        ch_ready,
  output logic        busy,
  output logic [5:0]  cur_row,
  output logic [6:0]  cur_col,
  output logic [12:0] ram_a,
  output logic [6:0]  ram_d,
  output logic        ram_we,
  input  logic [6:0]  ram_q
);

  localparam logic [5:0]  ROW_LAST = 6'(ROWS - 1);
  localparam logic [6:0]  COL_LAST = 7'(COLS - 1);
  localparam logic [12:0] STRIDE   = 13'(COLS);
  localparam logic [12:0] SCR_LAST = 13'((ROWS - 1) * COLS - 1);
  localparam logic [12:0] BOT_BASE = 13'((ROWS - 1) * COLS);
  localparam logic [12:0] BOT_LAST = 13'(COLS - 1);
  localparam logic [12:0] CLR_LAST = 13'(ROWS * COLS - 1);

  localparam logic [6:0] CH_BS    = 7'h08;
  localparam logic [6:0] CH_LF    = 7'h0A;
  localparam logic [6:0] CH_FF    = 7'h0C;
  localparam logic [6:0] CH_CR    = 7'h0D;
  localparam logic [6:0] CH_SPACE = 7'h20;
  localparam logic [6:0] CH_TILDE = 7'h7E;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PUT     = 3'd1,
    SCR_RD  = 3'd2,
    SCR_WR  = 3'd3,
    SCR_CLR = 3'd4,
    CLR     = 3'd5
  } state_t;

  state_t      state_q;
  logic [5:0]  row_q;
  logic [6:0]  col_q;
  logic [12:0] idx_q;       // scroll / clear index (i or j)
  logic [6:0]  hold_q;      // scroll holding register
  logic [6:0]  put_char_q;  // character written by PUT
  logic        put_bs_q;    // PUT is the blank of a backspace

  logic        printable;
  logic [6:0]  put_col;
  logic [12:0] put_addr;

  assign printable = (ch_data >= CH_SPACE) && (ch_data <= CH_TILDE);

  // A backspace writes one column left of the cursor; the cursor itself
  // moves back on the edge that leaves PUT, so the write and the cursor
  // agree on the "new" position.
  assign put_col  = put_bs_q ? (col_q - 7'd1) : col_q;
  assign put_addr = {7'd0, row_q} * STRIDE + {6'd0, put_col};

  assign ch_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign cur_row  = row_q;
  assign cur_col  = col_q;

  always_comb begin
    ram_a  = 13'd0;
    ram_d  = 7'd0;
    ram_we = 1'b0;
    case (state_q)
      PUT: begin
        ram_a  = put_addr;
        ram_d  = put_char_q;
        ram_we = 1'b1;
      end
      SCR_RD: begin
        ram_a = idx_q + STRIDE;
      end
      SCR_WR: begin
        ram_a  = idx_q;
        ram_d  = hold_q;
        ram_we = 1'b1;
      end
      SCR_CLR: begin
        ram_a  = BOT_BASE + idx_q;
        ram_d  = CH_SPACE;
        ram_we = 1'b1;
      end
      CLR: begin
        ram_a  = idx_q;
        ram_d  = CH_SPACE;
        ram_we = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= IDLE;
      row_q      <= 6'd0;
      col_q      <= 7'd0;
      idx_q      <= 13'd0;
      hold_q     <= 7'd0;
      put_char_q <= 7'd0;
      put_bs_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ch_valid) begin
            if (printable) begin
              put_char_q <= ch_data;
              put_bs_q   <= 1'b0;
              state_q    <= PUT;
            end else begin
              case (ch_data)
                CH_LF: begin
                  col_q <= 7'd0;
                  if (row_q < ROW_LAST) begin
                    row_q <= row_q + 6'd1;
                  end else begin
                    idx_q   <= 13'd0;
                    state_q <= SCR_RD;
                  end
                end
                CH_CR: col_q <= 7'd0;
                CH_BS: begin
                  if (col_q != 7'd0) begin
                    put_char_q <= CH_SPACE;
                    put_bs_q   <= 1'b1;
                    state_q    <= PUT;
                  end
                end
                CH_FF: begin
                  idx_q   <= 13'd0;
                  state_q <= CLR;
                end
                default: ;
              endcase
            end
          end
        end

        PUT: begin
          state_q <= IDLE;
          if (put_bs_q) begin
            col_q <= col_q - 7'd1;
          end else if (col_q == COL_LAST) begin
            col_q <= 7'd0;
            if (row_q == ROW_LAST) begin
              idx_q   <= 13'd0;
              state_q <= SCR_RD;
            end else begin
              row_q <= row_q + 6'd1;
            end
          end else begin
            col_q <= col_q + 7'd1;
          end
        end

        SCR_RD: begin
          hold_q  <= ram_q;
          state_q <= SCR_WR;
        end

        SCR_WR: begin
          if (idx_q == SCR_LAST) begin
            idx_q   <= 13'd0;
            state_q <= SCR_CLR;
          end else begin
            idx_q   <= idx_q + 13'd1;
            state_q <= SCR_RD;
          end
        end

        SCR_CLR: begin
          if (idx_q == BOT_LAST) begin
            idx_q   <= 13'd0;
            row_q   <= ROW_LAST;
            col_q   <= 7'd0;
            state_q <= IDLE;
          end else begin
            idx_q <= idx_q + 13'd1;
          end
        end

        CLR: begin
          if (idx_q == CLR_LAST) begin
            idx_q   <= 13'd0;
            row_q   <= 6'd0;
            col_q   <= 7'd0;
            state_q <= IDLE;
          end else begin
            idx_q <= idx_q + 13'd1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_console_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_console_ctrl
//
// Bench for vga_console_ctrl. Holds a behavioural character RAM the DUT
// writes into, plus a screen model (array image + cursor) that applies the
// console rules directly: print, wrap, LF, CR, BS, FF and whole-row scroll.
// ---------------------------------------------------------------------------
module tb_vga_console_ctrl;

  localparam int COLS = 80;
  localparam int ROWS = 59;
  localparam int AREA = ROWS * COLS;
  localparam int SCROLL_CYC = 2 * (ROWS - 1) * COLS + COLS;
  localparam int BOUND = 20000;

  logic        sys_clk = 1'b0;
  logic        clrn = 1'b0;
  logic        ch_valid = 1'b0;
  logic [6:0]  ch_data = 7'd0;
  logic        ch_ready;
  logic        busy;
  logic [5:0]  cur_row;
  logic [6:0]  cur_col;
  logic [12:0] ram_a;
  logic [6:0]  ram_d;
  logic        ram_we;
  logic [6:0]  ram_q;

  vga_console_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .sys_clk (sys_clk),
    .clrn    (clrn),
    .ch_valid(ch_valid),
    .ch_data (ch_data),
    .ch_ready(ch_ready),
    .busy    (busy),
    .cur_row (cur_row),
    .cur_col (cur_col),
    .ram_a   (ram_a),
    .ram_d   (ram_d),
    .ram_we  (ram_we),
    .ram_q   (ram_q)
  );

  always #10 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;

  // character RAM seen by the DUT; sync_req copies the model image into it
  logic [6:0]  mem     [0:8191];
  logic [6:0]  exp_mem [0:8191];
  logic        sync_req = 1'b0;
  int          wr_count = 0;
  int          bad_wr = 0;
  logic [12:0] last_wa = 13'd0;
  logic [6:0]  last_wd = 7'd0;

  assign ram_q = mem[ram_a];

  always @(posedge sys_clk or posedge sync_req) begin
    if (sync_req) begin
      for (int a = 0; a < 8192; a++) mem[a] <= exp_mem[a];
    end else if (ram_we === 1'b1) begin
      mem[ram_a] <= ram_d;
      wr_count = wr_count + 1;
      last_wa  = ram_a;
      last_wd  = ram_d;
      if (int'(ram_a) >= AREA) bad_wr = bad_wr + 1;
    end
  end

  // ---------------- screen model ----------------
  int m_row = 0;
  int m_col = 0;

  task automatic model_scroll();
    for (int r = 0; r < ROWS - 1; r++)
      for (int k = 0; k < COLS; k++)
        exp_mem[r * COLS + k] = exp_mem[(r + 1) * COLS + k];
    for (int k = 0; k < COLS; k++) exp_mem[(ROWS - 1) * COLS + k] = 7'h20;
  endtask

  // applies one code; occ = expected busy cycles after acceptance
  task automatic model_char(input logic [6:0] c, output int occ);
    occ = 0;
    if (c >= 7'h20 && c <= 7'h7E) begin
      exp_mem[m_row * COLS + m_col] = c;
      occ = 1;
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        if (m_row == ROWS - 1) begin
          model_scroll();
          occ += SCROLL_CYC;
        end else m_row++;
      end
    end else if (c == 7'h0A) begin
      m_col = 0;
      if (m_row < ROWS - 1) m_row++;
      else begin
        model_scroll();
        occ = SCROLL_CYC;
      end
    end else if (c == 7'h0D) begin
      m_col = 0;
    end else if (c == 7'h08) begin
      if (m_col > 0) begin
        m_col--;
        exp_mem[m_row * COLS + m_col] = 7'h20;
        occ = 1;
      end
    end else if (c == 7'h0C) begin
      for (int a = 0; a < AREA; a++) exp_mem[a] = 7'h20;
      m_row = 0;
      m_col = 0;
      occ = AREA;
    end
  endtask

  function automatic int mem_diff(input int lo, input int hi);
    int d = 0;
    for (int a = lo; a <= hi; a++) if (mem[a] !== exp_mem[a]) d++;
    return d;
  endfunction

  task automatic sync_mem();
    #1 sync_req = 1'b1;
    #1 sync_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    clrn = 1'b0;
    ch_valid = 1'b0;
    repeat (2) @(negedge sys_clk);
    clrn = 1'b1;
    m_row = 0;
    m_col = 0;
  endtask

  // offer one code, wait for acceptance, then for busy to drop
  task automatic send_char(input logic [6:0] c, output int occ);
    int n = 0;
    occ = 0;
    @(negedge sys_clk);
    ch_valid = 1'b1;
    ch_data  = c;
    while (ch_ready !== 1'b1 && n < BOUND) begin
      @(negedge sys_clk);
      n++;
    end
    if (ch_ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL accept_timeout code=%h ch_ready=%b required 1", c, ch_ready);
      ch_valid = 1'b0;
    end else begin
      @(negedge sys_clk);
      ch_valid = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < BOUND) begin
        occ++;
        @(negedge sys_clk);
        n++;
      end
      if (busy !== 1'b0) begin
        tests++; fails++;
        $display("FAIL idle_timeout code=%h busy=%b required 0", c, busy);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge sys_clk);
    clrn = 1'b0;
    repeat (2) @(negedge sys_clk);
    tests++; if (ch_ready !== 1'b1) begin fails++; $display("FAIL rst_ch_ready got %b required 1", ch_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b required 0", busy); end
    tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL rst_ram_we got %b required 0", ram_we); end
    tests++; if (ram_a !== 13'd0) begin fails++; $display("FAIL rst_ram_a got %0d required 0", ram_a); end
    tests++; if (ram_d !== 7'd0) begin fails++; $display("FAIL rst_ram_d got %h required 0", ram_d); end
    tests++; if (cur_row !== 6'd0 || cur_col !== 7'd0) begin
      fails++; $display("FAIL rst_cursor got (%0d,%0d) required (0,0)", cur_row, cur_col);
    end
    clrn = 1'b1;
    m_row = 0;
    m_col = 0;
  endtask

  task automatic test_first_char();
    int w0, occ;
    w0 = wr_count;
    ch_valid = 1'b1;
    ch_data  = 7'h41;
    tests++; if (ch_ready !== 1'b1) begin fails++; $display("FAIL a_ready got %b required 1", ch_ready); end
    @(negedge sys_clk);
    tests++; if (ram_we !== 1'b1 || ram_a !== 13'd0 || ram_d !== 7'h41) begin
      fails++; $display("FAIL a_write got we=%b a=%0d d=%h required we=1 a=0 d=41", ram_we, ram_a, ram_d);
    end
    tests++; if (ch_ready !== 1'b0) begin fails++; $display("FAIL a_busy_ready got %b required 0", ch_ready); end
    ch_data = 7'h42;
    @(negedge sys_clk);
    tests++; if (ch_ready !== 1'b1 || ram_we !== 1'b0 || cur_row !== 6'd0 || cur_col !== 7'd1) begin
      fails++; $display("FAIL a_after got ready=%b we=%b cur=(%0d,%0d) required ready=1 we=0 cur=(0,1)",
                        ch_ready, ram_we, cur_row, cur_col);
    end
    @(negedge sys_clk);
    tests++; if (ram_we !== 1'b1 || ram_a !== 13'd1 || ram_d !== 7'h42) begin
      fails++; $display("FAIL b_write got we=%b a=%0d d=%h required we=1 a=1 d=42", ram_we, ram_a, ram_d);
    end
    ch_valid = 1'b0;
    @(negedge sys_clk);
    tests++; if (wr_count - w0 != 2 || cur_col !== 7'd2) begin
      fails++; $display("FAIL ab_done got writes=%0d col=%0d required writes=2 col=2", wr_count - w0, cur_col);
    end
    model_char(7'h41, occ);
    model_char(7'h42, occ);
  endtask

  task automatic test_wrap_bs();
    int occ, eocc, w0;
    logic [6:0] c;
    do_reset();
    for (int k = 0; k < COLS; k++) begin
      c = 7'($urandom_range(32, 126));
      send_char(c, occ);
      model_char(c, eocc);
    end
    tests++; if (last_wa !== 13'd79 || cur_row !== 6'd1 || cur_col !== 7'd0) begin
      fails++; $display("FAIL wrap got last_a=%0d cur=(%0d,%0d) required last_a=79 cur=(1,0)", last_wa, cur_row, cur_col);
    end
    tests++; if (mem_diff(0, COLS - 1) != 0) begin
      fails++; $display("FAIL wrap_row0 got %0d bad cells required 0", mem_diff(0, COLS - 1));
    end
    // BS at column 0 does nothing
    w0 = wr_count;
    send_char(7'h08, occ);
    model_char(7'h08, eocc);
    tests++; if (wr_count != w0 || occ != 0 || cur_row !== 6'd1 || cur_col !== 7'd0) begin
      fails++; $display("FAIL bs_col0 got writes=%0d occ=%0d cur=(%0d,%0d) required writes=0 occ=0 cur=(1,0)",
                        wr_count - w0, occ, cur_row, cur_col);
    end
    send_char(7'h58, occ);
    model_char(7'h58, eocc);
    w0 = wr_count;
    send_char(7'h08, occ);
    model_char(7'h08, eocc);
    tests++; if (wr_count - w0 != 1 || last_wa !== 13'd80 || last_wd !== 7'h20 || occ != 1 ||
                 cur_row !== 6'd1 || cur_col !== 7'd0) begin
      fails++; $display("FAIL bs_mid got writes=%0d a=%0d d=%h occ=%0d cur=(%0d,%0d) required 1 80 20 1 (1,0)",
                        wr_count - w0, last_wa, last_wd, occ, cur_row, cur_col);
    end
  endtask

  task automatic test_scroll();
    int occ, eocc, n, bad_occ, b0;
    do_reset();
    for (int k = 0; k < ROWS; k++)
      for (int c = 0; c < COLS; c++) exp_mem[k * COLS + c] = 7'(8'h30 + k % 10);
    sync_mem();
    bad_occ = 0;
    for (int k = 0; k < ROWS - 1; k++) begin
      send_char(7'h0A, occ);
      model_char(7'h0A, eocc);
      if (occ != eocc) bad_occ++;
    end
    for (int k = 0; k < 5; k++) begin
      send_char(7'h38, occ);
      model_char(7'h38, eocc);
      if (occ != eocc) bad_occ++;
    end
    tests++; if (bad_occ != 0 || cur_row !== 6'd58 || cur_col !== 7'd5) begin
      fails++; $display("FAIL scroll_setup got bad_occ=%0d cur=(%0d,%0d) required 0 (58,5)", bad_occ, cur_row, cur_col);
    end
    b0 = bad_wr;
    @(negedge sys_clk);
    ch_valid = 1'b1;
    ch_data  = 7'h0A;
    @(negedge sys_clk);
    ch_data = 7'h5A;
    n = 0;
    while (ch_ready !== 1'b1 && n < BOUND) begin
      n++;
      @(negedge sys_clk);
    end
    tests++; if (n != SCROLL_CYC) begin
      fails++; $display("FAIL scroll_cycles got %0d required %0d", n, SCROLL_CYC);
    end
    @(negedge sys_clk);
    ch_valid = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < BOUND) begin n++; @(negedge sys_clk); end
    model_char(7'h0A, eocc);
    model_char(7'h5A, eocc);
    tests++; if (cur_row !== 6'd58 || cur_col !== 7'd1) begin
      fails++; $display("FAIL scroll_cursor got (%0d,%0d) required (58,1)", cur_row, cur_col);
    end
    tests++; if (mem_diff(0, AREA - 1) != 0) begin
      fails++; $display("FAIL scroll_image got %0d bad cells required 0", mem_diff(0, AREA - 1));
    end
    tests++; if (mem[0] !== 7'h31 || mem[57 * COLS] !== 7'h38 || mem[58 * COLS + 1] !== 7'h20) begin
      fails++; $display("FAIL scroll_rows got %h %h %h required 31 38 20", mem[0], mem[57 * COLS], mem[58 * COLS + 1]);
    end
    tests++; if (bad_wr != b0) begin
      fails++; $display("FAIL scroll_status_line got %0d writes required 0", bad_wr - b0);
    end
  endtask

  task automatic test_clear();
    int occ, eocc, errs;
    do_reset();
    for (int k = 0; k < 10; k++) begin send_char(7'h0A, occ); model_char(7'h0A, eocc); end
    for (int k = 0; k < 10; k++) begin send_char(7'h2A, occ); model_char(7'h2A, eocc); end
    tests++; if (cur_row !== 6'd10 || cur_col !== 7'd10) begin
      fails++; $display("FAIL ff_setup got (%0d,%0d) required (10,10)", cur_row, cur_col);
    end
    @(negedge sys_clk);
    ch_valid = 1'b1;
    ch_data  = 7'h0C;
    @(negedge sys_clk);
    ch_valid = 1'b0;
    errs = 0;
    for (int n = 0; n < AREA; n++) begin
      if (ram_we !== 1'b1 || int'(ram_a) != n || ram_d !== 7'h20) errs++;
      @(negedge sys_clk);
    end
    model_char(7'h0C, eocc);
    tests++; if (errs != 0) begin fails++; $display("FAIL ff_sequence got %0d bad cycles required 0", errs); end
    tests++; if (busy !== 1'b0 || cur_row !== 6'd0 || cur_col !== 7'd0) begin
      fails++; $display("FAIL ff_done got busy=%b cur=(%0d,%0d) required busy=0 (0,0)", busy, cur_row, cur_col);
    end
    tests++; if (mem_diff(0, AREA - 1) != 0) begin
      fails++; $display("FAIL ff_image got %0d bad cells required 0", mem_diff(0, AREA - 1));
    end
  endtask

  task automatic test_ignored();
    logic [6:0] codes [0:4];
    int occ, eocc, w0, errs;
    codes[0] = 7'h00; codes[1] = 7'h1B; codes[2] = 7'h7F; codes[3] = 7'h01; codes[4] = 7'h1F;
    send_char(7'h51, occ);
    model_char(7'h51, eocc);
    w0 = wr_count;
    errs = 0;
    ch_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ch_data = codes[i];
      @(negedge sys_clk);
      if (busy !== 1'b0 || ch_ready !== 1'b1) errs++;
      model_char(codes[i], eocc);
    end
    tests++; if (errs != 0 || wr_count != w0 || cur_row !== 6'(m_row) || cur_col !== 7'(m_col)) begin
      fails++; $display("FAIL ignored got errs=%0d writes=%0d cur=(%0d,%0d) required 0 0 (%0d,%0d)",
                        errs, wr_count - w0, cur_row, cur_col, m_row, m_col);
    end
    ch_data = 7'h0D;
    @(negedge sys_clk);
    model_char(7'h0D, eocc);
    ch_data = 7'h0A;
    tests++; if (busy !== 1'b0 || cur_row !== 6'd0 || cur_col !== 7'd0) begin
      fails++; $display("FAIL cr_b2b got busy=%b cur=(%0d,%0d) required 0 (0,0)", busy, cur_row, cur_col);
    end
    @(negedge sys_clk);
    model_char(7'h0A, eocc);
    ch_valid = 1'b0;
    tests++; if (busy !== 1'b0 || cur_row !== 6'd1 || cur_col !== 7'd0) begin
      fails++; $display("FAIL lf_b2b got busy=%b cur=(%0d,%0d) required 0 (1,0)", busy, cur_row, cur_col);
    end
  endtask

  task automatic test_reset_mid_scroll();
    int occ, eocc, w0;
    do_reset();
    for (int k = 0; k < ROWS - 1; k++) begin send_char(7'h0A, occ); model_char(7'h0A, eocc); end
    @(negedge sys_clk);
    ch_valid = 1'b1;
    ch_data  = 7'h0A;
    @(negedge sys_clk);
    ch_valid = 1'b0;
    repeat (99) @(negedge sys_clk);
    clrn = 1'b0;
    #1;
    tests++; if (ram_we !== 1'b0 || cur_row !== 6'd0 || cur_col !== 7'd0 || ch_ready !== 1'b1) begin
      fails++; $display("FAIL mid_reset got we=%b cur=(%0d,%0d) ready=%b required 0 (0,0) 1",
                        ram_we, cur_row, cur_col, ch_ready);
    end
    @(negedge sys_clk);
    clrn = 1'b1;
    m_row = 0;
    m_col = 0;
    w0 = wr_count;
    send_char(7'h42, occ);
    model_char(7'h42, eocc);
    tests++; if (wr_count - w0 != 1 || last_wa !== 13'd0 || last_wd !== 7'h42) begin
      fails++; $display("FAIL mid_reset_b got writes=%0d a=%0d d=%h required 1 0 42", wr_count - w0, last_wa, last_wd);
    end
  endtask

  task automatic test_random();
    int occ, eocc, r, b0;
    logic [6:0] c;
    logic [6:0] junk [0:3];
    junk[0] = 7'h00; junk[1] = 7'h07; junk[2] = 7'h1B; junk[3] = 7'h7F;
    do_reset();
    send_char(7'h0C, occ);
    model_char(7'h0C, eocc);
    tests++; if (occ != eocc) begin fails++; $display("FAIL rnd_ff_occ got %0d required %0d", occ, eocc); end
    for (int k = 0; k < ROWS - 2; k++) begin send_char(7'h0A, occ); model_char(7'h0A, eocc); end
    b0 = bad_wr;
    for (int k = 0; k < 100; k++) begin
      r = $urandom_range(0, 99);
      if (r < 3) c = 7'h0A;
      else if (r < 9) c = 7'h08;
      else if (r < 12) c = 7'h0D;
      else if (r < 15) c = junk[$urandom_range(0, 3)];
      else c = 7'($urandom_range(32, 126));
      send_char(c, occ);
      model_char(c, eocc);
      tests++; if (occ != eocc || cur_row !== 6'(m_row) || cur_col !== 7'(m_col)) begin
        fails++; $display("FAIL rnd_step%0d code=%h got occ=%0d cur=(%0d,%0d) required occ=%0d cur=(%0d,%0d)",
                          k, c, occ, cur_row, cur_col, eocc, m_row, m_col);
      end
    end
    tests++; if (mem_diff(0, AREA - 1) != 0) begin
      fails++; $display("FAIL rnd_image got %0d bad cells required 0", mem_diff(0, AREA - 1));
    end
    tests++; if (bad_wr != b0) begin
      fails++; $display("FAIL rnd_status_line got %0d writes required 0", bad_wr - b0);
    end
  endtask

  initial begin
    for (int a = 0; a < 8192; a++) exp_mem[a] = 7'($urandom);
    sync_mem();
    test_reset();
    test_first_char();
    test_wrap_bs();
    test_scroll();
    test_clear();
    test_ignored();
    test_reset_mid_scroll();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
